// File: rtl/q_adapt_serial_pkg.sv
// Shared definitions for the adaptive Q estimator: mode encodings, FSM
// state constants and the saturation helper used by every datapath stage.
package q_adapt_serial_pkg;

  // Q construction modes; encoding 3 behaves like the full outer product.
  localparam logic [1:0] Q_MODE_ISO  = 2'd0;
  localparam logic [1:0] Q_MODE_DIAG = 2'd1;
  localparam logic [1:0] Q_MODE_FULL = 2'd2;

  // Sequencer states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DIFF = 2'd1;
  localparam logic [1:0] ST_MUL  = 2'd2;
  localparam logic [1:0] ST_UPD  = 2'd3;

  // Full outer product for mode 2 and for the spare encoding 3.
  function automatic logic is_full_mode(input logic [1:0] m);
    return (m != Q_MODE_ISO) && (m != Q_MODE_DIAG);
  endfunction

  // Clamp a wide signed value into the n-bit two's-complement range.
  // Callers narrow the result to their own word width.
  function automatic logic signed [63:0] sat_wide(input logic signed [63:0] v,
                                                  input int unsigned     n);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (n - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/q_adapt_serial_if.sv
// Request / result bundle of the adaptive Q estimator.
interface q_adapt_serial_if #(
  parameter int N   = 20,
  parameter int DIM = 2
);
  logic                    start;
  logic                    clr;
  logic [1:0]              mode;
  logic [DIM*N-1:0]        x_now;
  logic [DIM*N-1:0]        x_prev;
  logic                    busy;
  logic                    done;
  logic [DIM*DIM*N-1:0]    q_flat;

  // Requester side (KF control / testbench).
  modport master (
    output start, clr, mode, x_now, x_prev,
    input  busy, done, q_flat
  );

  // Estimator side.
  modport slave (
    input  start, clr, mode, x_now, x_prev,
    output busy, done, q_flat
  );
endinterface

// File: rtl/fxp_mul.sv
// Saturating signed fixed-point multiplier: y = sat_N((a * b) >>> FRAC).
module fxp_mul
  import q_adapt_serial_pkg::*;
#(
  parameter int N    = 20,
  parameter int FRAC = 10
) (
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  output logic signed [N-1:0] y
);

  function automatic logic signed [N-1:0] sat_n(input logic signed [63:0] v);
    return N'(sat_wide(v, N));
  endfunction

  logic signed [2*N-1:0] prod;

  // Full-precision product, then rescale back to the shared Q format.
  assign prod = (2*N)'(a) * (2*N)'(b);
  assign y    = sat_n(64'(prod >>> FRAC));

endmodule

// File: rtl/fxp_sub.sv
// Saturating signed fixed-point subtractor: y = sat_N(a - b).
module fxp_sub
  import q_adapt_serial_pkg::*;
#(
  parameter int N = 20
) (
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  output logic signed [N-1:0] y
);

  function automatic logic signed [N-1:0] sat_n(input logic signed [63:0] v);
    return N'(sat_wide(v, N));
  endfunction

  logic signed [N:0] diff;

  // One guard bit is enough to hold any difference of two N-bit words.
  assign diff = (N+1)'(a) - (N+1)'(b);
  assign y    = sat_n(64'(diff));

endmodule

// File: rtl/q_pair_seq.sv
// Walks the (r,c) index pairs visited by the multiply phase: the diagonal
// for modes 0/1, the r-major upper triangle for the full mode.
module q_pair_seq #(
  parameter int DIM = 2,
  parameter int IW  = (DIM > 1) ? $clog2(DIM) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          advance,
  input  logic          full,
  output logic [IW-1:0] r,
  output logic [IW-1:0] c,
  output logic          last
);

  localparam logic [IW-1:0] LAST_IDX = IW'(DIM - 1);

  // Both sequences finish on the bottom-right element.
  assign last = (r == LAST_IDX) && (c == LAST_IDX);

  // Restart at (0,0) on load, otherwise step to the next pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0;
      c <= '0;
    end else if (load) begin
      r <= '0;
      c <= '0;
    end else if (advance && !last) begin
      if (full) begin
        if (c == LAST_IDX) begin
          r <= r + 1'b1;
          c <= r + 1'b1;
        end else begin
          c <= c + 1'b1;
        end
      end else begin
        r <= r + 1'b1;
        c <= c + 1'b1;
      end
    end
  end

endmodule

// File: rtl/q_adapt_serial.sv
// Adaptive process-noise estimator. Forms dx = now - prev one component per
// cycle, builds the Q products on a single shared multiplier, shapes them
// per mode and optionally smooths the result with a power-of-two EMA.
module q_adapt_serial
  import q_adapt_serial_pkg::*;
#(
  parameter int N        = 20,
  parameter int FRAC     = 10,
  parameter int DIM      = 2,
  parameter int ALPHA_SH = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  q_adapt_serial_if.slave bus
);

  localparam int IW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int LG = $clog2(DIM);
  localparam int AW = N + LG;

  typedef logic signed [N-1:0] word_t;

  function automatic word_t sat_n(input logic signed [63:0] v);
    return N'(sat_wide(v, N));
  endfunction

  logic [1:0]        state;
  logic              busy_q;
  logic              done_q;
  logic              seeded;
  logic [1:0]        mode_l;
  logic [DIM*N-1:0]  now_l;
  logic [DIM*N-1:0]  prev_l;
  logic [IW-1:0]     diff_idx;

  word_t now_w  [DIM];
  word_t prev_w [DIM];
  word_t dx     [DIM];
  word_t raw    [DIM][DIM];
  word_t q      [DIM*DIM];
  word_t q_next [DIM*DIM];

  word_t         sub_y;
  word_t         mul_y;
  logic [IW-1:0] seq_r;
  logic [IW-1:0] seq_c;
  logic          seq_last;

  // Unpack the latched input vectors and pack Q for the output bus.
  for (genvar i = 0; i < DIM; i++) begin : g_unpack
    assign now_w[i]  = now_l[i*N +: N];
    assign prev_w[i] = prev_l[i*N +: N];
  end

  for (genvar k = 0; k < DIM*DIM; k++) begin : g_pack
    assign bus.q_flat[k*N +: N] = q[k];
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;

  // Single time-shared subtractor and multiplier.
  fxp_sub #(.N(N)) u_sub (
    .a (now_w[diff_idx]),
    .b (prev_w[diff_idx]),
    .y (sub_y)
  );

  fxp_mul #(.N(N), .FRAC(FRAC)) u_mul (
    .a (dx[seq_r]),
    .b (dx[seq_c]),
    .y (mul_y)
  );

  q_pair_seq #(.DIM(DIM), .IW(IW)) u_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (state != ST_MUL),
    .advance (state == ST_MUL),
    .full    (is_full_mode(mode_l)),
    .r       (seq_r),
    .c       (seq_c),
    .last    (seq_last)
  );

  logic signed [AW-1:0] acc;
  word_t                avg;
  word_t                rm;
  logic signed [N:0]    dlt;
  logic signed [N+1:0]  nxt;

  // Shape the raw products per mode and apply the EMA to get next Q.
  always_comb begin
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    acc = '0;
    avg = '0;
    rm  = '0;
    dlt = '0;
    nxt = '0;
    for (int k = 0; k < DIM*DIM; k++) q_next[k] = q[k];

    for (int i = 0; i < DIM; i++) acc = acc + AW'(raw[i][i]);
    avg = sat_n(64'(acc >>> LG));

    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        if (is_full_mode(mode_l)) rm = (r <= c) ? raw[r][c] : raw[c][r];
        else if (r == c)          rm = (mode_l == Q_MODE_ISO) ? avg : raw[r][c];
        else                      rm = '0;

        if (!seeded || ALPHA_SH == 0) begin
          q_next[r*DIM+c] = rm;
        end else begin
          dlt = (N+1)'(rm) - (N+1)'(q[r*DIM+c]);
          nxt = (N+2)'(q[r*DIM+c]) + (N+2)'(dlt >>> ALPHA_SH);
          q_next[r*DIM+c] = sat_n(64'(nxt));
        end
      end
    end
  end

  // Job sequencer: latch, subtract, multiply, publish; clr aborts anything.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is written with <= so every reader sees the pre-edge value.
    if (!rst_n) begin
      state    <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      seeded   <= 1'b0;
      mode_l   <= '0;
      now_l    <= '0;
      prev_l   <= '0;
      diff_idx <= '0;
      // NOTE: the small working arrays are reset too, so no register ever holds an unknown.
      for (int i = 0; i < DIM; i++) begin
        dx[i] <= '0;
        for (int j = 0; j < DIM; j++) raw[i][j] <= '0;
      end
      for (int k = 0; k < DIM*DIM; k++) q[k] <= '0;
    end else if (bus.clr) begin
      state  <= ST_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      seeded <= 1'b0;
      for (int k = 0; k < DIM*DIM; k++) q[k] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            now_l    <= bus.x_now;
            prev_l   <= bus.x_prev;
            mode_l   <= bus.mode;
            diff_idx <= '0;
            busy_q   <= 1'b1;
            state    <= ST_DIFF;
          end
        end
        ST_DIFF: begin
          dx[diff_idx] <= sub_y;
          if (diff_idx == IW'(DIM - 1)) state <= ST_MUL;
          else                          diff_idx <= diff_idx + 1'b1;
        end
        ST_MUL: begin
          raw[seq_r][seq_c] <= mul_y;
          if (seq_last) state <= ST_UPD;
        end
        ST_UPD: begin
          for (int k = 0; k < DIM*DIM; k++) q[k] <= q_next[k];
          seeded <= 1'b1;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_q_adapt_serial.sv
// Bench for q_adapt_serial: two instances (no smoothing and alpha = 1/4)
// share one stimulus stream; a plain-arithmetic model predicts both.
module tb_q_adapt_serial;

  localparam int N    = 20;
  localparam int FRAC = 10;
  localparam int DIM  = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic clr;
  logic [1:0] mode;
  logic [DIM*N-1:0] x_now;
  logic [DIM*N-1:0] x_prev;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  q_adapt_serial_if #(.N(N), .DIM(DIM)) if0 ();
  q_adapt_serial_if #(.N(N), .DIM(DIM)) if2 ();

  assign if0.start = start;  assign if2.start = start;
  assign if0.clr   = clr;    assign if2.clr   = clr;
  assign if0.mode  = mode;   assign if2.mode  = mode;
  assign if0.x_now = x_now;  assign if2.x_now = x_now;
  assign if0.x_prev = x_prev; assign if2.x_prev = x_prev;

  q_adapt_serial #(.N(N), .FRAC(FRAC), .DIM(DIM), .ALPHA_SH(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0));
  q_adapt_serial #(.N(N), .FRAC(FRAC), .DIM(DIM), .ALPHA_SH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2));

  // ---------------- reference model ----------------
  logic signed [N-1:0] in_now  [DIM];
  logic signed [N-1:0] in_prev [DIM];
  longint mq     [2][DIM*DIM];
  bit     mseed  [2];
  int     msh    [2] = '{0, 2};

  function automatic longint satn(input longint v);
    longint hi = (64'sd1 <<< (N - 1)) - 1;
    longint lo = -(64'sd1 <<< (N - 1));
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction

  function automatic longint qv(input int which, input int k);
    if (which == 0) return longint'($signed(if0.q_flat[k*N +: N]));
    return longint'($signed(if2.q_flat[k*N +: N]));
  endfunction

  function automatic int exp_lat(input logic [1:0] m);
    return DIM + ((m >= 2) ? DIM * (DIM + 1) / 2 : DIM) + 1;
  endfunction

  task automatic model_clear();
    for (int a = 0; a < 2; a++) begin
      mseed[a] = 1'b0;
      for (int k = 0; k < DIM*DIM; k++) mq[a][k] = 0;
    end
  endtask

  task automatic model_job(input logic [1:0] m);
    longint dx [DIM];
    longint tgt [DIM*DIM];
    longint s;
    s = 0;
    for (int i = 0; i < DIM; i++)
      dx[i] = satn(longint'(in_now[i]) - longint'(in_prev[i]));
    for (int i = 0; i < DIM; i++) s += satn((dx[i] * dx[i]) >>> FRAC);
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        if (m >= 2)      tgt[r*DIM+c] = satn((dx[r] * dx[c]) >>> FRAC);
        else if (r != c) tgt[r*DIM+c] = 0;
        else if (m == 1) tgt[r*DIM+c] = satn((dx[r] * dx[r]) >>> FRAC);
        else             tgt[r*DIM+c] = satn(s / DIM);
      end
    for (int a = 0; a < 2; a++) begin
      for (int k = 0; k < DIM*DIM; k++)
        if (!mseed[a] || msh[a] == 0) mq[a][k] = tgt[k];
        else mq[a][k] = satn(mq[a][k] + ((tgt[k] - mq[a][k]) >>> msh[a]));
      mseed[a] = 1'b1;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_inputs(input int n0, input int n1, input int p0, input int p1);
    in_now[0] = N'(n0);  in_now[1] = N'(n1);
    in_prev[0] = N'(p0); in_prev[1] = N'(p1);
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < DIM; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_now[i]  = N'($urandom);
        in_prev[i] = N'($urandom);
      end else begin
        in_now[i]  = N'(int'($urandom_range(0, 8191)) - 4096);
        in_prev[i] = N'(int'($urandom_range(0, 8191)) - 4096);
      end
    end
  endtask

  // Launch one job; report edges-to-done (-1 on timeout) and handshake sanity.
  // Bus inputs are scrambled after acceptance to prove they were latched.
  task automatic do_job(input logic [1:0] m, output int lat, output bit flags_ok);
    @(negedge clk);
    mode = m;
    for (int i = 0; i < DIM; i++) begin
      x_now[i*N +: N]  = in_now[i];
      x_prev[i*N +: N] = in_prev[i];
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode = 2'($urandom);
    x_now = {DIM{N'($urandom)}};
    x_prev = {DIM{N'($urandom)}};
    flags_ok = (if0.busy === 1'b1) && (if2.busy === 1'b1);
    lat = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (if2.done !== if0.done) flags_ok = 1'b0;
      if (if0.done === 1'b1) begin
        lat = e;
        if (if0.busy !== 1'b0) flags_ok = 1'b0;
        break;
      end else if (if0.busy !== 1'b1) flags_ok = 1'b0;
    end
    if (lat > 0) begin
      @(posedge clk);
      #1;
      if (if0.done !== 1'b0) flags_ok = 1'b0;
    end
    model_job(m);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; clr = 1'b0; mode = '0; x_now = '0; x_prev = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (if0.busy !== 1'b0 || if2.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b/%b want 0", if0.busy, if2.busy);
    end
    n_tests++;
    if (if0.done !== 1'b0 || if2.done !== 1'b0) begin
      n_fail++; $display("FAIL reset_done: got %b/%b want 0", if0.done, if2.done);
    end
    n_tests++;
    if (if0.q_flat !== '0 || if2.q_flat !== '0) begin
      n_fail++; $display("FAIL reset_q: got %h/%h want 0", if0.q_flat, if2.q_flat);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_iso_diag();
    int lat; bit ok;
    longint want [4] = '{4096, 0, 0, 4096};
    set_inputs(3072, 0, 1024, 2048);
    do_job(2'd0, lat, ok);
    n_tests++;
    if (lat !== 5) begin n_fail++; $display("FAIL iso_latency: got %0d want 5", lat); end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL iso_handshake: busy/done sequence wrong"); end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (qv(0, k) !== want[k]) begin
        n_fail++; $display("FAIL iso_q%0d: got %0d want %0d", k, qv(0, k), want[k]);
      end
    end
  endtask

  task automatic test_full();
    int lat; bit ok;
    longint want [4] = '{4096, -4096, -4096, 4096};
    set_inputs(3072, 0, 1024, 2048);
    do_job(2'd2, lat, ok);
    n_tests++;
    if (lat !== 6) begin n_fail++; $display("FAIL full_latency: got %0d want 6", lat); end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL full_handshake: busy/done sequence wrong"); end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (qv(0, k) !== want[k]) begin
        n_fail++; $display("FAIL full_q%0d: got %0d want %0d", k, qv(0, k), want[k]);
      end
    end
  endtask

  task automatic test_per_axis();
    int lat; bit ok;
    longint want [4] = '{1024, 0, 0, 9216};
    set_inputs(1024, 3072, 0, 0);
    do_job(2'd1, lat, ok);
    n_tests++;
    if (lat !== 5) begin n_fail++; $display("FAIL diag_latency: got %0d want 5", lat); end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (qv(0, k) !== want[k]) begin
        n_fail++; $display("FAIL diag_q%0d: got %0d want %0d", k, qv(0, k), want[k]);
      end
    end
  endtask

  task automatic test_saturation();
    int lat; bit ok;
    set_inputs(524287, 0, -524288, 0);
    do_job(2'd1, lat, ok);
    n_tests++;
    if (qv(0, 0) !== 524287) begin
      n_fail++; $display("FAIL sat_q11: got %0d want 524287", qv(0, 0));
    end
    n_tests++;
    if (qv(0, 3) !== 0) begin
      n_fail++; $display("FAIL sat_q22: got %0d want 0", qv(0, 3));
    end
  endtask

  task automatic test_ema();
    int lat; bit ok;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    model_clear();
    set_inputs(3072, 0, 1024, 2048);
    do_job(2'd0, lat, ok);
    n_tests++;
    if (qv(1, 0) !== 4096) begin
      n_fail++; $display("FAIL ema_seed: got %0d want 4096", qv(1, 0));
    end
    set_inputs(0, 0, 0, 0);
    do_job(2'd0, lat, ok);
    n_tests++;
    if (qv(1, 0) !== 3072 || qv(1, 3) !== 3072) begin
      n_fail++; $display("FAIL ema_step: got %0d/%0d want 3072", qv(1, 0), qv(1, 3));
    end
    n_tests++;
    if (qv(0, 0) !== 0) begin
      n_fail++; $display("FAIL ema_raw_path: got %0d want 0", qv(0, 0));
    end
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    model_clear();
    n_tests++;
    if (if2.q_flat !== '0) begin
      n_fail++; $display("FAIL ema_clr: got %h want 0", if2.q_flat);
    end
    set_inputs(3072, 0, 1024, 2048);
    do_job(2'd0, lat, ok);
    n_tests++;
    if (qv(1, 0) !== 4096) begin
      n_fail++; $display("FAIL ema_reseed: got %0d want 4096", qv(1, 0));
    end
  endtask

  task automatic test_random();
    int lat; bit ok;
    logic [1:0] m;
    for (int j = 0; j < 24; j++) begin
      rand_inputs();
      m = 2'($urandom);
      do_job(m, lat, ok);
      n_tests++;
      if (lat !== exp_lat(m) || !ok) begin
        n_fail++; $display("FAIL rand%0d_timing: lat %0d want %0d ok=%b", j, lat, exp_lat(m), ok);
      end
      for (int a = 0; a < 2; a++)
        for (int k = 0; k < DIM*DIM; k++) begin
          n_tests++;
          if (qv(a, k) !== mq[a][k]) begin
            n_fail++;
            $display("FAIL rand%0d_dut%0d_q%0d: got %0d want %0d", j, a*2, k, qv(a, k), mq[a][k]);
          end
        end
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2; bit ok1, ok2;
    rand_inputs();
    do_job(2'd2, lat1, ok1);
    rand_inputs();
    do_job(2'd1, lat2, ok2);
    n_tests++;
    if (lat1 !== 6 || lat2 !== 5 || !ok1 || !ok2) begin
      n_fail++; $display("FAIL b2b_timing: got %0d,%0d want 6,5", lat1, lat2);
    end
    for (int k = 0; k < DIM*DIM; k++) begin
      n_tests++;
      if (qv(1, k) !== mq[1][k]) begin
        n_fail++; $display("FAIL b2b_q%0d: got %0d want %0d", k, qv(1, k), mq[1][k]);
      end
    end
  endtask

  // Starts a job and leaves the bench just after the requested edge.
  task automatic launch_to_edge(input logic [1:0] m, input int edge_n);
    @(negedge clk);
    mode = m;
    for (int i = 0; i < DIM; i++) begin
      x_now[i*N +: N]  = in_now[i];
      x_prev[i*N +: N] = in_prev[i];
    end
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    x_now = {DIM{N'($urandom)}};
    repeat (edge_n) @(posedge clk);
    #1;
  endtask

  task automatic test_control();
    int dones;
    // Second start mid-job is neither honoured nor queued.
    rand_inputs();
    launch_to_edge(2'd2, 1);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    model_job(2'd2);
    dones = 0;
    for (int e = 0; e < 30; e++) begin
      @(posedge clk); #1;
      if (if0.done === 1'b1) dones++;
    end
    n_tests++;
    if (dones !== 1) begin n_fail++; $display("FAIL ctl_restart_dones: got %0d want 1", dones); end
    for (int k = 0; k < DIM*DIM; k++) begin
      n_tests++;
      if (qv(0, k) !== mq[0][k]) begin
        n_fail++; $display("FAIL ctl_restart_q%0d: got %0d want %0d", k, qv(0, k), mq[0][k]);
      end
    end

    // clr mid-job aborts with no done.
    rand_inputs();
    launch_to_edge(2'd0, 2);
    @(negedge clk) clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    model_clear();
    n_tests++;
    if (if0.busy !== 1'b0 || if0.q_flat !== '0 || if2.q_flat !== '0) begin
      n_fail++; $display("FAIL ctl_clr_state: busy %b q %h want 0", if0.busy, if0.q_flat);
    end
    dones = 0;
    for (int e = 0; e < 15; e++) begin
      @(posedge clk); #1;
      if (if0.done === 1'b1 || if2.done === 1'b1) dones++;
    end
    n_tests++;
    if (dones !== 0) begin n_fail++; $display("FAIL ctl_clr_dones: got %0d want 0", dones); end

    // start and clr together: clr wins.
    @(negedge clk); start = 1'b1; clr = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; clr = 1'b0;
    n_tests++;
    if (if0.busy !== 1'b0) begin
      n_fail++; $display("FAIL ctl_start_clr: busy %b want 0", if0.busy);
    end

    // Asynchronous reset mid-job: outputs drop immediately, no done later.
    rand_inputs();
    in_now[0] = N'(5000); in_prev[0] = N'(0);
    begin
      int lat; bit ok;
      do_job(2'd1, lat, ok);
    end
    launch_to_edge(2'd1, 1);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    n_tests++;
    if (if0.busy !== 1'b0 || if0.done !== 1'b0 || if0.q_flat !== '0 || if2.q_flat !== '0) begin
      n_fail++;
      $display("FAIL ctl_async_rst: busy %b done %b q %h want 0", if0.busy, if0.done, if0.q_flat);
    end
    @(negedge clk) rst_n = 1'b1;
    dones = 0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      if (if0.done === 1'b1) dones++;
    end
    n_tests++;
    if (dones !== 0) begin n_fail++; $display("FAIL ctl_rst_dones: got %0d want 0", dones); end
  endtask

  initial begin
    test_reset();
    test_iso_diag();
    test_full();
    test_per_axis();
    test_saturation();
    test_ema();
    test_random();
    test_back_to_back();
    test_control();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
